// File: rtl/key_loader.sv
// rtl/key_loader.sv - streams DATA_W-bit words into a KEY_W key, checks framing, commits with one write strobe
// Optional feature: KEY_LOADER_LOCK_EN blocks further loads after the first successful commit until rst.
module key_loader #(
    parameter int DATA_W         = 32,
    parameter int KEY_W          = 128,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              key_we,
    output logic [KEY_W-1:0]  key_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic              locked
);

    localparam int WORDS = KEY_W / DATA_W;
    localparam int CNT_W = $clog2(WORDS + 1);
    localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(WORDS - 1);
    // Timer counts idle cycles; the step that would reach TIMEOUT_CYCLES-1 is the timeout.
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES - 2);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] COMMIT  = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_SHORT   = 2'b01;
    localparam logic [1:0] ERR_LONG    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    logic [1:0]       state;
    logic [KEY_W-1:0] key_buf;
    logic [KEY_W-1:0] key_shifted;
    logic [CNT_W-1:0] cnt;
    logic [TMR_W-1:0] timer;
    logic             at_last_word;

    assign s_ready      = (state == COLLECT);
    assign busy         = (state != IDLE);
    assign key_we       = (state == COMMIT);
    assign done         = (state == DONE);
    // Key material is gated so it only leaves the block during the commit cycle.
    assign key_wdata    = key_we ? key_buf : '0;
    assign key_shifted  = KEY_W'({key_buf, s_data});
    assign at_last_word = (cnt == LAST_IDX);

`ifdef KEY_LOADER_LOCK_EN
    logic locked_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            locked_q <= 1'b0;
        end else if (state == DONE) begin
            locked_q <= 1'b1;
        end
    end

    assign locked = locked_q;
`else
    assign locked = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            key_buf  <= '0;
            cnt      <= '0;
            timer    <= '0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !locked) begin
                        state    <= COLLECT;
                        key_buf  <= '0;
                        cnt      <= '0;
                        timer    <= '0;
                        err      <= 1'b0;
                        err_code <= ERR_NONE;
                    end
                end
                COLLECT: begin
                    if (s_valid) begin
                        timer <= '0;
                        if (s_last && !at_last_word) begin
                            state    <= IDLE;
                            key_buf  <= '0;
                            err      <= 1'b1;
                            err_code <= ERR_SHORT;
                        end else if (at_last_word && !s_last) begin
                            state    <= IDLE;
                            key_buf  <= '0;
                            err      <= 1'b1;
                            err_code <= ERR_LONG;
                        end else begin
                            key_buf <= key_shifted;
                            cnt     <= cnt + 1'b1;
                            if (at_last_word) begin
                                state <= COMMIT;
                            end
                        end
                    end else if (timer == TMR_LIMIT) begin
                        state    <= IDLE;
                        key_buf  <= '0;
                        err      <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                COMMIT: begin
                    state <= DONE;
                end
                DONE: begin
                    key_buf <= '0;
                    state   <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    key_buf <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_loader.sv
// tb/tb_key_loader.sv - directed self-checking bench for key_loader
module tb_key_loader;

    localparam int TMO = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         s_valid;
    logic [31:0]  s_data;
    logic         s_last;
    logic         s_ready;
    logic         key_we;
    logic [127:0] key_wdata;
    logic         busy;
    logic         done;
    logic         err;
    logic [1:0]   err_code;
    logic         locked;

    int n_cmp  = 0;
    int n_bad  = 0;
    int we_cnt = 0;

    key_loader #(.DATA_W(32), .KEY_W(128), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_last(s_last), .s_ready(s_ready), .key_we(key_we), .key_wdata(key_wdata),
        .busy(busy), .done(done), .err(err), .err_code(err_code), .locked(locked)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (key_we) we_cnt++;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!s_ready && n < 20) begin
            step(1);
            n++;
        end
        if (!s_ready) check("ready_wait", s_ready, 1'b1);
        step(1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
    endtask

    task automatic good_load(input string tag, input logic [127:0] key);
        int we0;
        we0 = we_cnt;
        do_start();
        check({tag, "_err_clr"}, {err, err_code}, 3'b000);
        for (int w = 0; w < 4; w++) send_word(key[127-32*w -: 32], w == 3);
        check({tag, "_we"}, key_we, 1'b1);
        check({tag, "_wdata"}, key_wdata, key);
        step(1);
        check({tag, "_done"}, {done, key_we}, 2'b10);
        check({tag, "_wdata_off"}, key_wdata, 128'h0);
        step(1);
        check({tag, "_idle"}, {busy, done, err}, 3'b000);
        check({tag, "_we_once"}, we_cnt - we0, 1);
    endtask

    initial begin
        int we0;
        rst = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;

        do_reset();
        check("rst_ctl", {s_ready, key_we, busy, done, err, err_code, locked}, 8'h00);
        check("rst_wdata", key_wdata, 128'h0);

        // s_valid in IDLE is not consumed
        s_valid = 1'b1; s_data = 32'hFFFF_FFFF;
        step(2);
        check("idle_no_ready", {s_ready, busy}, 2'b00);
        s_valid = 1'b0;

        good_load("t1", 128'h00112233_44556677_8899AABB_CCDDEEFF);

        // short key
        do_reset();
        we0 = we_cnt;
        do_start();
        check("t2_collect", {busy, s_ready}, 2'b11);
        send_word(32'hAAAA_0001, 1'b0);
        send_word(32'hAAAA_0002, 1'b1);
        check("t2_err", {err, err_code, busy}, 4'b1010);
        check("t2_no_we", we_cnt - we0, 0);

        // long key, start mid-load is ignored; then a good load recovers
        do_reset();
        we0 = we_cnt;
        do_start();
        send_word(32'h1, 1'b0);
        send_word(32'h2, 1'b0);
        do_start();
        send_word(32'h3, 1'b0);
        check("t3_mid", {busy, err}, 2'b10);
        send_word(32'h4, 1'b0);
        check("t3_err", {err, err_code, busy}, 4'b1100);
        step(3);
        check("t3_err_hold", {err, err_code}, 3'b110);
        check("t3_no_we", we_cnt - we0, 0);
        good_load("t3b", 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98);

        // timeout
        do_reset();
        we0 = we_cnt;
        do_start();
        send_word(32'h5555_5555, 1'b0);
        step(TMO / 2);
        check("t4_wait", {busy, err}, 2'b10);
        step(TMO / 2);
        check("t4_err", {err, err_code, busy}, 4'b1110);
        check("t4_no_we", we_cnt - we0, 0);

        // reset mid-load
        do_reset();
        we0 = we_cnt;
        do_start();
        send_word(32'hBAD0_0001, 1'b0);
        send_word(32'hBAD0_0002, 1'b0);
        send_word(32'hBAD0_0003, 1'b0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("t5_rst", {s_ready, key_we, busy, done, err, err_code, locked}, 8'h00);
        check("t5_wdata", key_wdata, 128'h0);
        check("t5_no_we", we_cnt - we0, 0);
        good_load("t5b", 128'h11111111_22222222_33333333_44444444);

        // lock behaviour
        do_reset();
        good_load("t6a", 128'hCAFEF00D_00000001_00000002_00000003);
`ifdef KEY_LOADER_LOCK_EN
        check("t6_locked", locked, 1'b1);
        we0 = we_cnt;
        do_start();
        check("t6_blocked", {busy, s_ready}, 2'b00);
        step(4);
        check("t6_no_we", we_cnt - we0, 0);
        do_reset();
        check("t6_unlock", locked, 1'b0);
`else
        check("t6_unlocked", locked, 1'b0);
        good_load("t6b", 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
